// File: rtl/seven_seg_scan_mux.sv
// seven_seg_scan_mux: time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Optional build macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zeros in digits 3..1.
// Ports:
//   clock       rising-edge clock
//   reset_n     synchronous active-low reset
//   enable      scan enable; low blanks the display and freezes the scan
//   digits_bcd  four BCD nibbles, [3:0] = digit 0 (least significant)
//   dp_in       decimal point request per digit
//   digit       active-low one-hot digit enables
//   segments    active-low segment pattern {g,f,e,d,c,b,a}
//   dp          active-low decimal point
//   frame_done  one-cycle pulse after a new frame is latched
module seven_seg_scan_mux #(
    parameter int PRESCALE = 50000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] digits_bcd,
    input  logic [3:0]  dp_in,
    output logic [3:0]  digit,
    output logic [6:0]  segments,
    output logic        dp,
    output logic        frame_done
);
    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [1:0]    nidx;
    logic [15:0]   shadow;
    logic [15:0]   src;
    logic [3:0]    nib;
    logic [6:0]    seg_next;
    logic          tick;
    logic          wrap;
    logic          lat;
    logic          blank;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        tick = cnt == CW'(PRESCALE - 1);
        wrap = idx == 2'd3;
        nidx = idx + 2'd1;
        // On the wrapping tick the shadow is being loaded, so digit 0 decodes the incoming value
        src  = wrap ? digits_bcd : shadow;
        nib  = src[{nidx, 2'b00} +: 4];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        blank = (nidx == 2'd1 && src[15:4] == 12'd0) ||
                (nidx == 2'd2 && src[15:8] == 8'd0) ||
                (nidx == 2'd3 && src[15:12] == 4'd0);
`else
        blank = 1'b0;
`endif
        seg_next = blank ? 7'b1111111 : dec(nib);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt        <= '0;
            idx        <= 2'd3;
            shadow     <= '0;
            digit      <= 4'b1111;
            segments   <= 7'b1111111;
            dp         <= 1'b1;
            lat        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // frame_done trails the latching edge by one cycle
            lat        <= enable && tick && wrap;
            frame_done <= lat;
            if (!enable) begin
                digit    <= 4'b1111;
                segments <= 7'b1111111;
                dp       <= 1'b1;
            end else begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick) begin
                    idx      <= nidx;
                    digit    <= ~(4'b0001 << nidx);
                    segments <= seg_next;
                    dp       <= ~dp_in[nidx];
                    if (wrap) shadow <= digits_bcd;
                end
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// tb_seven_seg_scan_mux: directed scoreboard bench for seven_seg_scan_mux at PRESCALE=4.
module tb_seven_seg_scan_mux;
    localparam int P = 4;
    localparam logic [11:0] BLANK = {4'b1111, 7'b1111111, 1'b1};

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] digits_bcd;
    logic [3:0]  dp_in;
    logic [3:0]  digit;
    logic [6:0]  segments;
    logic        dp;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    logic [11:0] q[$];

    always #5 clock = ~clock;

    seven_seg_scan_mux #(.PRESCALE(P)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .digits_bcd(digits_bcd),
        .dp_in(dp_in), .digit(digit), .segments(segments), .dp(dp), .frame_done(frame_done)
    );

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] mseg(input logic [15:0] sh, input int i);
        logic [15:0] hi;
        hi = sh >> (4 * i);
        mseg = dec(hi[3:0]);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (i > 0 && hi == 16'd0) mseg = 7'b1111111;
`endif
    endfunction

    task automatic push(input logic [15:0] sh, input int i, input logic [3:0] dpv);
        logic [3:0] d;
        d = ~(4'b0001 << i);
        q.push_back({d, mseg(sh, i), ~dpv[i]});
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got digit/seg/dp=%b/%b/%b want=%b/%b/%b",
                   tag, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic fd(input string tag, input logic exp);
        total++;
        assert (frame_done === exp) else begin
            bad++;
            $error("FAIL %s frame_done got=%b want=%b", tag, frame_done, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            chk(tag, {digit, segments, dp}, q.pop_front());
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; digits_bcd = 16'h1234; dp_in = 4'hF;
        cyc(3);
        chk("reset", {digit, segments, dp}, BLANK);
        fd("reset_fd", 1'b0);
        // Scenario 1
        reset_n = 1'b1; dp_in = 4'b0101;
        push(16'h1234, 0, dp_in); push(16'h1234, 1, dp_in);
        cyc(3); chk("pre_tick", {digit, segments, dp}, BLANK);
        cyc(1); pop_chk("s1_d0"); fd("s1_fd_lo", 1'b0);
        cyc(1); fd("s1_fd", 1'b1);
        cyc(1); fd("s1_fd_end", 1'b0);
        cyc(2); pop_chk("s1_d1");
        // Scenario 2: change input while idx=1
        digits_bcd = 16'h5678;
        push(16'h1234, 2, dp_in); push(16'h1234, 3, dp_in);
        push(16'h5678, 0, dp_in); push(16'h5678, 1, dp_in);
        cyc(4); pop_chk("s2_d2");
        cyc(4); pop_chk("s2_d3");
        cyc(4); pop_chk("s2_d0");
        cyc(1); fd("s2_fd", 1'b1);
        cyc(3); pop_chk("s2_d1");
        // Scenario 3: non-BCD nibble in digit 2
        digits_bcd = 16'h0A00;
        push(16'h5678, 2, dp_in); push(16'h5678, 3, dp_in);
        push(16'h0A00, 0, dp_in); push(16'h0A00, 1, dp_in); push(16'h0A00, 2, dp_in);
        cyc(4); pop_chk("s3_d2_old");
        cyc(4); pop_chk("s3_d3_old");
        cyc(4); pop_chk("s3_d0");
        cyc(4); pop_chk("s3_d1");
        cyc(4); pop_chk("s3_d2_blank");
        // Scenario 4: enable drop at idx=2 for 10 cycles
        enable = 1'b0;
        cyc(1); chk("s4_off", {digit, segments, dp}, BLANK);
        cyc(9); chk("s4_hold", {digit, segments, dp}, BLANK); fd("s4_fd", 1'b0);
        enable = 1'b1;
        push(16'h0A00, 3, dp_in);
        cyc(3); chk("s4_wait", {digit, segments, dp}, BLANK);
        cyc(1); pop_chk("s4_resume_d3");
        // Enable drop coincident with a pending wrap tick: no advance, no latch
        cyc(3);
        enable = 1'b0;
        cyc(1); chk("s4_tick_off", {digit, segments, dp}, BLANK);
        cyc(1); fd("s4_nolatch", 1'b0);
        // Scenario 5: leading zeros
        digits_bcd = 16'h0007; enable = 1'b1;
        push(16'h0007, 0, dp_in);
        cyc(1); pop_chk("s5_d0");
        cyc(1); fd("s5_fd", 1'b1);
        push(16'h0007, 1, dp_in); push(16'h0007, 2, dp_in); push(16'h0007, 3, dp_in);
        push(16'h0007, 0, dp_in); push(16'h0007, 1, dp_in);
        cyc(3); pop_chk("s5_d1");
        cyc(4); pop_chk("s5_d2");
        cyc(4); pop_chk("s5_d3");
        cyc(4); pop_chk("s5_d0b");
        cyc(4); pop_chk("s5_d1b");
        // Scenario 6: reset mid-frame at idx=1
        dp_in = 4'hF;
        cyc(2);
        reset_n = 1'b0;
        cyc(1); chk("s6_reset", {digit, segments, dp}, BLANK); fd("s6_fd_lo", 1'b0);
        reset_n = 1'b1;
        push(16'h0007, 0, dp_in);
        cyc(3); chk("s6_pre", {digit, segments, dp}, BLANK);
        cyc(1); pop_chk("s6_d0");
        cyc(1); fd("s6_fd", 1'b1);
        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL leftover scoreboard entries got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
